// File: rtl/request_arbiter_if.sv
// ----------------------------------------------------------------------------
// request_arbiter_if
//   Bundles the datapath-side request/response signals and the RAM-side
//   strobes of the request arbiter.
//
//   Datapath -> arbiter : iREN, iaddr, dREN, dWEN, daddr, dstore, halt
//   RAM      -> arbiter : ramload, ramready
//   Arbiter  -> RAM     : ramREN, ramWEN, ramaddr, ramstore
//   Arbiter  -> datapath: ihit, dhit, iload, dload, halted, err
//
//   slave  : the arbiter's view (receives requests, drives RAM and responses)
//   master : the environment's view (datapath + RAM model)
// ----------------------------------------------------------------------------
interface request_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        halt;
    logic [31:0] ramload;
    logic        ramready;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        halted;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload,
               halted, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload,
               halted, err
    );
endinterface

// File: rtl/request_arbiter.sv
// ----------------------------------------------------------------------------
// request_arbiter
//   Arbitrates a single-ported RAM between instruction fetch and data
//   load/store requests. Data wins a simultaneous request, except that the
//   grant following a data response goes to a waiting fetch. Each access
//   waits for ramready; a bounded wait counter turns a stuck RAM into a
//   sticky error state. HALT stops all further grants once pending data has
//   been serviced.
//
//   Parameters: TIMEOUT - RAM wait cycles per access before error (1..16)
//   Ports     : CLK  - rising-edge clock
//               nRST - asynchronous active-low reset
//               arb  - request_arbiter_if.slave bundle (see interface file)
// ----------------------------------------------------------------------------
module request_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               nRST,
    request_arbiter_if.slave   arb
);

    typedef enum logic [2:0] {
        IDLE, IACC, DACC, IRESP, DRESP, HALTED, ERR
    } state_t;

    // Wait-counter value on the last permitted ACC cycle without ramready.
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_wr;
    logic [3:0]  r_cnt;
    logic [31:0] r_iload;
    logic [31:0] r_dload;
    logic        r_ipri;      // fetch owns the next grant after a data response
    logic        r_halt_req;  // halt seen; remembered so a short pulse still halts

    logic        w_halt;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_cnt_inc;
    logic        w_ramREN;
    logic        w_ramWEN;
    logic [31:0] w_ramaddr;
    logic [31:0] w_ramstore;

    assign w_halt = arb.halt | r_halt_req;

    // NOTE: state is reset asynchronously and updated with non-blocking
    // assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal written here receives a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_grant_i  = 1'b0;
        w_grant_d  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_ramREN   = 1'b0;
        w_ramWEN   = 1'b0;
        w_ramaddr  = '0;
        w_ramstore = '0;

        case (r_state)
            IDLE: begin
                if (r_ipri && arb.iREN && !w_halt) begin
                    w_next    = IACC;
                    w_grant_i = 1'b1;
                end else if (arb.dREN || arb.dWEN) begin
                    w_next    = DACC;
                    w_grant_d = 1'b1;
                end else if (arb.iREN && !w_halt) begin
                    w_next    = IACC;
                    w_grant_i = 1'b1;
                end else if (w_halt) begin
                    w_next = HALTED;
                end
            end
            IACC, DACC: begin
                // RAM sees only values latched at grant time, so the
                // datapath may change or drop its request mid-access.
                w_ramaddr = r_addr;
                if (r_state == IACC) begin
                    w_ramREN = 1'b1;
                end else begin
                    w_ramWEN   = r_wr;
                    w_ramREN   = !r_wr;
                    w_ramstore = r_store;
                end
                if (arb.ramready) begin
                    w_next = (r_state == IACC) ? IRESP : DRESP;
                end else if (r_cnt == LAST_WAIT) begin
                    w_next = ERR;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            IRESP, DRESP: w_next = IDLE;
            HALTED:       w_next = HALTED;
            ERR:          w_next = ERR;
            default:      w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr     <= '0;
            r_store    <= '0;
            r_wr       <= 1'b0;
            r_cnt      <= '0;
            r_iload    <= '0;
            r_dload    <= '0;
            r_ipri     <= 1'b0;
            r_halt_req <= 1'b0;
        end else begin
            if (w_grant_i) begin
                r_addr  <= arb.iaddr;
                r_store <= '0;
                r_wr    <= 1'b0;
                r_cnt   <= '0;
            end else if (w_grant_d) begin
                r_addr  <= arb.daddr;
                r_store <= arb.dstore;
                r_wr    <= arb.dWEN;   // a write wins if both ops are raised
                r_cnt   <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (r_state == IACC && arb.ramready) begin
                r_iload <= arb.ramload;
            end
            if (r_state == DACC && arb.ramready && !r_wr) begin
                r_dload <= arb.ramload;
            end

            // Priority is armed only by a data response and consumed by the
            // IDLE cycle that follows it.
            if (r_state == DRESP) begin
                r_ipri <= arb.iREN;
            end else if (r_state == IDLE) begin
                r_ipri <= 1'b0;
            end

            if (arb.halt) begin
                r_halt_req <= 1'b1;
            end
        end
    end

    assign arb.ramREN   = w_ramREN;
    assign arb.ramWEN   = w_ramWEN;
    assign arb.ramaddr  = w_ramaddr;
    assign arb.ramstore = w_ramstore;
    assign arb.ihit     = (r_state == IRESP);
    assign arb.dhit     = (r_state == DRESP);
    assign arb.iload    = r_iload;
    assign arb.dload    = r_dload;
    assign arb.halted   = (r_state == HALTED);
    assign arb.err      = (r_state == ERR);

endmodule
